// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for a single-port register-file memory: one write or read burst per command.
// Optional abort input/aborted output are enabled with `define MEM_BURST_ABORT_EN.
module mem_burst_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [N-1:0] cmd_addr,
  input  logic [N-1:0] cmd_len,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [N-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N-1:0] rd_data,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         busy,
  output logic         done,
`ifdef MEM_BURST_ABORT_EN
  input  logic         abort,
  output logic         aborted,
`endif
  output logic [2:0]   fsm_state
);

  // Valid/ready: a word moves on a rising edge where valid && ready; valid never waits on ready.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD_REQ = 3'd2,
    RD_LAT = 3'd3,
    RD_OUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] addr_q, addr_nx;
  logic [N-1:0] remaining, remaining_nx;
  logic [N-1:0] rd_q, rd_nx;
  logic         abort_hit;

`ifdef MEM_BURST_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort && (state inside {WR, RD_REQ, RD_LAT, RD_OUT});
  assign aborted   = (state == DONE) && aborted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted_q <= 1'b0;
    else      aborted_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    remaining_nx = remaining;
    rd_nx        = rd_q;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_nx      = cmd_addr;
          remaining_nx = cmd_len;
          state_nx     = cmd_write ? WR : RD_REQ;
        end
      end
      WR: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_wdata = wr_data;
        if (wr_valid) begin
          if (remaining == '0) begin
            state_nx = DONE;
          end else begin
            addr_nx      = addr_q + 1'b1;
            remaining_nx = remaining - 1'b1;
          end
        end
      end
      RD_REQ: state_nx = RD_LAT;
      RD_LAT: begin
        rd_nx    = mem_rdata;
        state_nx = RD_OUT;
      end
      RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (remaining == '0) begin
            state_nx = DONE;
          end else begin
            addr_nx      = addr_q + 1'b1;
            remaining_nx = remaining - 1'b1;
            state_nx     = RD_REQ;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort ends the burst; a word handshaking this edge has already been delivered.
    if (abort_hit) begin
      state_nx     = DONE;
      addr_nx      = addr_q;
      remaining_nx = remaining;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      rd_q      <= '0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      remaining <= remaining_nx;
      rd_q      <= rd_nx;
    end
  end

  assign mem_addr  = addr_q;
  assign rd_data   = rd_q;
  assign fsm_state = state;

endmodule
